wrr_starve_arbiter: RTL

WRR_STARVE_ARBITER -- requirements
Module: wrr_starve_arbiter

---
 rtl/wrr_starve_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/wrr_starve_arbiter.sv
// Request arbiter with fixed, round-robin and weighted round-robin modes.
// Grants are registered and held until released; long waiters escalate to top priority.
module wrr_starve_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 4,
  parameter int MAX_WAIT = 50
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*WEIGHT_W-1:0] weight,
  input  logic [1:0]                  mode,
  input  logic                        done,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
  output logic [NUM_REQ-1:0]          starve
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic {ARB = 1'b0, GRANT = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_s;
  logic                gnt_valid_r, gnt_valid_s;
  logic [ID_W-1:0]     gnt_id_r, gnt_id_s;
  logic [ID_W-1:0]     ptr_r, ptr_s;
  logic [WEIGHT_W-1:0] used_r [NUM_REQ];
  logic [WEIGHT_W-1:0] used_s [NUM_REQ];
  logic [7:0]          wait_r [NUM_REQ];
  logic [7:0]          wait_s [NUM_REQ];
  logic [NUM_REQ-1:0]  starve_r, starve_s;
  logic [NUM_REQ-1:0]  starved_req_s;
  logic [ID_W-1:0]     winner_s, next_id_s;
  logic [WEIGHT_W-1:0] win_weight_s, eff_weight_s;
  logic                credit_done_s;

  // First set bit of v searching upward from start, wrapping at NUM_REQ-1.
  function automatic logic [ID_W-1:0] first_from(input logic [NUM_REQ-1:0] v,
                                                 input logic [ID_W-1:0] start);
    logic [2*NUM_REQ-1:0] dbl;
    logic [ID_W-1:0]      pick;
    int                   pos;
    dbl  = {v, v} >> start;
    pick = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos  = int'(start) + k;
      pos  = (pos >= NUM_REQ) ? pos - NUM_REQ : pos;
      pick = dbl[k] ? ID_W'(pos) : pick;
    end
    return pick;
  endfunction

  // Winner selection and mode-2 credit evaluation.
  always_comb begin
    starved_req_s = starve_r & req;
    if (|starved_req_s) begin
      winner_s = first_from(starved_req_s, {ID_W{1'b0}});
    end else if (mode == 2'd0) begin
      winner_s = first_from(req, {ID_W{1'b0}});
    end else begin
      winner_s = first_from(req, ptr_r);
    end
    next_id_s    = (winner_s == LAST_ID) ? {ID_W{1'b0}} : winner_s + ID_W'(1);
    win_weight_s = {WEIGHT_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      win_weight_s = (winner_s == ID_W'(i)) ? weight[i*WEIGHT_W +: WEIGHT_W] : win_weight_s;
    end
    eff_weight_s  = (win_weight_s == {WEIGHT_W{1'b0}}) ? WEIGHT_W'(1) : win_weight_s;
    credit_done_s = (({1'b0, used_r[winner_s]} + (WEIGHT_W+1)'(1)) >= {1'b0, eff_weight_s});
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ARB: begin
        if (|req) state_s = GRANT;
        else      state_s = ARB;
      end
      GRANT: begin
        if (done || !req[gnt_id_r]) state_s = ARB;
        else                        state_s = GRANT;
      end
      default: state_s = ARB;
    endcase
  end

  // Grant, pointer and credit updates for the coming edge.
  always_comb begin
    gnt_s       = gnt_r;
    gnt_valid_s = gnt_valid_r;
    gnt_id_s    = gnt_id_r;
    ptr_s       = ptr_r;
    used_s      = used_r;
    case (state_r)
      ARB: begin
        if (|req) begin
          gnt_s       = NUM_REQ'(1) << winner_s;
          gnt_valid_s = 1'b1;
          gnt_id_s    = winner_s;
          case (mode)
            2'd0: ptr_s = ptr_r;
            2'd2: begin
              if (credit_done_s) begin
                used_s[winner_s] = {WEIGHT_W{1'b0}};
                ptr_s            = next_id_s;
              end else begin
                used_s[winner_s] = used_r[winner_s] + WEIGHT_W'(1);
                ptr_s            = winner_s;
              end
            end
            default: ptr_s = next_id_s;
          endcase
        end else begin
          gnt_s       = {NUM_REQ{1'b0}};
          gnt_valid_s = 1'b0;
        end
      end
      GRANT: begin
        if (state_s == ARB) begin
          gnt_s       = {NUM_REQ{1'b0}};
          gnt_valid_s = 1'b0;
        end else begin
          gnt_s       = gnt_r;
          gnt_valid_s = gnt_valid_r;
        end
      end
      default: begin
        gnt_s       = {NUM_REQ{1'b0}};
        gnt_valid_s = 1'b0;
      end
    endcase
  end

  // Wait counters saturate at the threshold; starve mirrors the saturated value.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_r[i] || !req[i])       wait_s[i] = 8'd0;
      else if (wait_r[i] == WAIT_MAX) wait_s[i] = WAIT_MAX;
      else                            wait_s[i] = wait_r[i] + 8'd1;
      starve_s[i] = (wait_s[i] == WAIT_MAX);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ARB;
      gnt_r       <= {NUM_REQ{1'b0}};
      gnt_valid_r <= 1'b0;
      gnt_id_r    <= {ID_W{1'b0}};
      ptr_r       <= {ID_W{1'b0}};
      starve_r    <= {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
        used_r[i] <= {WEIGHT_W{1'b0}};
        wait_r[i] <= 8'd0;
      end
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      gnt_valid_r <= gnt_valid_s;
      gnt_id_r    <= gnt_id_s;
      ptr_r       <= ptr_s;
      starve_r    <= starve_s;
      used_r      <= used_s;
      wait_r      <= wait_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_valid = gnt_valid_r;
  assign gnt_id    = gnt_id_r;
  assign starve    = starve_r;

endmodule
